// File: rtl/parking_sensor_gen.sv
// rtl/parking_sensor_gen.sv - emulated two-sensor car passage generator with occupancy count
module parking_sensor_gen #(
  parameter int PHASE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int CAPACITY     = 15,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic             cmd_dir,
  output logic             cmd_ready,
  output logic             sensor1,
  output logic             sensor2,
  output logic             done,
  output logic             reject,
  output logic [CNT_W-1:0] occupancy
);

  localparam int MAXC = (PHASE_CYCLES > GAP_CYCLES) ? PHASE_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0]    P_LOAD = CW'(PHASE_CYCLES - 1);
  localparam logic [CW-1:0]    G_LOAD = CW'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP    = CNT_W'(CAPACITY);

  typedef enum logic [2:0] {IDLE, LEAD, BOTH, TRAIL, GAP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          dir;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= P_LOAD;
      dir       <= 1'b0;
      cmd_ready <= 1'b1;
      sensor1   <= 1'b0;
      sensor2   <= 1'b0;
      done      <= 1'b0;
      reject    <= 1'b0;
      occupancy <= '0;
    end else begin
      done   <= 1'b0;
      reject <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            // impossible moves are refused without leaving IDLE
            if ((!cmd_dir && occupancy == CAP) || (cmd_dir && occupancy == '0)) begin
              reject <= 1'b1;
            end else begin
              state     <= LEAD;
              cnt       <= P_LOAD;
              dir       <= cmd_dir;
              cmd_ready <= 1'b0;
              sensor1   <= ~cmd_dir;
              sensor2   <= cmd_dir;
            end
          end
        end
        LEAD: begin
          if (cnt == '0) begin
            state   <= BOTH;
            cnt     <= P_LOAD;
            sensor1 <= 1'b1;
            sensor2 <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        BOTH: begin
          if (cnt == '0) begin
            state   <= TRAIL;
            cnt     <= P_LOAD;
            sensor1 <= dir;
            sensor2 <= ~dir;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        TRAIL: begin
          if (cnt == '0) begin
            state     <= GAP;
            cnt       <= G_LOAD;
            sensor1   <= 1'b0;
            sensor2   <= 1'b0;
            done      <= 1'b1;
            occupancy <= dir ? occupancy - CNT_W'(1) : occupancy + CNT_W'(1);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state     <= IDLE;
            cnt       <= P_LOAD;
            cmd_ready <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          cnt       <= P_LOAD;
          cmd_ready <= 1'b1;
          sensor1   <= 1'b0;
          sensor2   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_sensor_gen.sv
// tb/tb_parking_sensor_gen.sv - randomized and directed check of parking_sensor_gen against a timeline model
module tb_parking_sensor_gen;
  localparam int P = 4;
  localparam int G = 2;
  localparam int CAP = 2;
  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_dir = 1'b0;
  logic cmd_ready, sensor1, sensor2, done, reject;
  logic [CNT_W-1:0] occupancy;

  parking_sensor_gen #(.PHASE_CYCLES(P), .GAP_CYCLES(G), .CAPACITY(CAP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
    .cmd_ready(cmd_ready), .sensor1(sensor1), .sensor2(sensor2),
    .done(done), .reject(reject), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // model: mk = cycles since acceptance (0 = idle)
  int mk = 0;
  int mocc = 0;
  bit mdir = 1'b0;
  bit mrej = 1'b0;
  int done_enter = 0;
  int done_exit = 0;

  // loopback decoder of sensor patterns
  logic [1:0] hist [3];
  int hn = 0;
  logic [1:0] lastp = 2'b00;
  int dec_incr = 0;
  int dec_decr = 0;
  int s1_rises = 0;

  int base = 0;
  int log_s1 [0:31];
  int log_s2 [0:31];
  int log_done [0:31];
  int log_rdy [0:31];
  int log_occ [0:31];

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic model_reset();
    mk = 0; mocc = 0; mrej = 1'b0; hn = 0; lastp = 2'b00;
  endtask

  task automatic decode(input logic [1:0] p);
    if (p != lastp) begin
      if (p == 2'b00) begin
        if (hn == 3 && hist[0] == 2'b10 && hist[1] == 2'b11 && hist[2] == 2'b01) dec_incr++;
        if (hn == 3 && hist[0] == 2'b01 && hist[1] == 2'b11 && hist[2] == 2'b10) dec_decr++;
        hn = 0;
      end else if (hn < 3) begin
        hist[hn] = p;
        hn++;
      end else begin
        hn = 4;
      end
      if (p[1] && !lastp[1]) s1_rises++;
      lastp = p;
    end
  endtask

  task automatic step(input bit v, input bit d);
    bit lead, trail;
    int off;
    @(negedge clk);
    cyc++;
    lead  = (mk >= 1) && (mk <= 2 * P);
    trail = (mk >= P + 1) && (mk <= 3 * P);
    chk("cmd_ready", int'(cmd_ready), int'(mk == 0));
    chk("sensor1", int'(sensor1), int'(mdir ? trail : lead));
    chk("sensor2", int'(sensor2), int'(mdir ? lead : trail));
    chk("done", int'(done), int'(mk == 3 * P + 1));
    chk("reject", int'(reject), int'(mrej));
    chk("occupancy", int'(occupancy), mocc);
    decode({sensor1, sensor2});
    off = cyc - base;
    if (off >= 0 && off < 32) begin
      log_s1[off] = int'(sensor1); log_s2[off] = int'(sensor2);
      log_done[off] = int'(done); log_rdy[off] = int'(cmd_ready);
      log_occ[off] = int'(occupancy);
    end
    cmd_valid = v;
    cmd_dir = d;
    mrej = 1'b0;
    if (mk != 0) begin
      mk++;
      if (mk == 3 * P + 1) begin
        mocc = mdir ? mocc - 1 : mocc + 1;
        if (mdir) done_exit++; else done_enter++;
      end
      if (mk == 3 * P + G + 1) mk = 0;
    end else if (v) begin
      if ((!d && mocc == CAP) || (d && mocc == 0)) mrej = 1'b1;
      else begin
        mk = 1;
        mdir = d;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    int r0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_sensors", int'({sensor1, sensor2, done, reject}), 0);
    chk("rst_occ", int'(occupancy), 0);
    model_reset();
    idle(10);

    // enter at offset 0, pinned against hand-computed timeline
    base = cyc + 1;
    step(1'b1, 1'b0);
    idle(16);
    chk("lit_s1_first", log_s1[1], 1);
    chk("lit_s1_last", log_s1[8], 1);
    chk("lit_s1_off", log_s1[9], 0);
    chk("lit_s2_pre", log_s2[4], 0);
    chk("lit_s2_first", log_s2[5], 1);
    chk("lit_s2_last", log_s2[12], 1);
    chk("lit_done13", log_done[13], 1);
    chk("lit_occ12", log_occ[12], 0);
    chk("lit_occ13", log_occ[13], 1);
    chk("lit_rdy14", log_rdy[14], 0);
    chk("lit_rdy15", log_rdy[15], 1);

    // exit back to zero, then exit from empty
    base = cyc + 1;
    step(1'b1, 1'b1);
    idle(16);
    chk("lit_exit_s2", log_s2[1], 1);
    chk("lit_exit_s1", log_s1[4], 0);
    chk("lit_exit_occ", log_occ[13], 0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    chk("lit_rej_empty", int'(reject), 1);
    idle(3);

    // fill to capacity, third enter refused
    step(1'b1, 1'b0); idle(15);
    step(1'b1, 1'b0); idle(15);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    chk("lit_rej_full", int'(reject), 1);
    chk("lit_occ_full", int'(occupancy), 2);
    idle(3);

    // drain, then hold cmd_valid high
    step(1'b1, 1'b1); idle(15);
    step(1'b1, 1'b1); idle(15);
    r0 = s1_rises;
    for (int i = 0; i < 50; i++) step(1'b1, 1'b0);
    idle(2);
    chk("lit_hold_accepts", s1_rises - r0, 2);
    chk("lit_hold_occ", int'(occupancy), 2);

    // async reset mid-BOTH
    step(1'b1, 1'b1);
    idle(6);
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_sensors", int'({sensor1, sensor2}), 0);
    chk("async_occ", int'(occupancy), 0);
    chk("async_ready", int'(cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0); idle(16);
    chk("lit_post_rst_occ", int'(occupancy), 1);

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    idle(20);

    chk("loop_incr", dec_incr, done_enter);
    chk("loop_decr", dec_decr, done_exit);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
